// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin, packet-locking arbiter that lets NREQ byte
// sources share one uart_tx. A grant is held until the owner's last byte
// or the MAX_BURST cap. The line is then drained to idle before the next
// owner is picked.
//
// Handshake rule on every port: a byte moves on a clock edge where
// valid && ready are both high. valid never waits on ready. Once a source
// raises valid, the data stays put until the transfer happens.
module uart_tx_arb #(
  parameter int NREQ      = 2,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]    req_valid_i,
  input  logic [NREQ*DW-1:0] req_data_i,
  input  logic [NREQ-1:0]    req_last_i,
  output logic [NREQ-1:0]    req_ready_o,
  output logic [DW-1:0]      tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  input  logic              tx_busy_i,
  output logic [NREQ-1:0]    grant_o,
  output logic              burst_cut_o,
  output logic [1:0]         state_o
);

  localparam int GW = $clog2(NREQ);
  // A zero-width counter is not legal, so the unlimited case keeps 1 bit.
  localparam int CW = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_CAP = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_XFER  = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [GW-1:0]   gidx_q, gidx_d;
  logic [GW-1:0]   last_g_q, last_g_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      flush_q, flush_d;
  logic            cut_q, cut_d;
  logic            txv_q, txv_d;
  logic [DW-1:0]   txd_q, txd_d;

  logic            slot_free;
  logic            own_valid;
  logic            own_last;
  logic [DW-1:0]   own_data;
  logic            accept;
  logic [CW-1:0]   cnt_inc;
  logic            cap_hit;
  logic            rr_any;
  logic [GW-1:0]   rr_pick;

  assign slot_free = !txv_q || tx_ready_i;
  assign own_valid = req_valid_i[gidx_q];
  assign own_last  = req_last_i[gidx_q];
  assign own_data  = req_data_i[gidx_q*DW +: DW];
  // No handshake may complete while reset is asserted.
  assign accept    = (state_q == S_XFER) && slot_free && own_valid && !rst_i;
  assign cnt_inc   = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  assign cap_hit   = (MAX_BURST != 0) && (cnt_inc == BURST_CAP);

  // Round-robin search starting one past the previous owner, wrapping.
  always_comb begin
    logic [GW-1:0] cand;
    rr_any  = 1'b0;
    rr_pick = '0;
    cand    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = GW'((int'(last_g_q) + i) % NREQ);
      if (!rr_any && req_valid_i[cand]) begin
        rr_any  = 1'b1;
        rr_pick = cand;
      end
    end
  end

  // Only the owner sees ready, and only while the output slot can take a byte.
  always_comb begin
    req_ready_o = '0;
    if (state_q == S_XFER && slot_free && !rst_i) begin
      req_ready_o = grant_q;
    end
  end

  // Output register: loads on accept, empties when uart_tx takes the byte.
  always_comb begin
    txv_d = txv_q;
    txd_d = txd_q;
    if (accept) begin
      txv_d = 1'b1;
      txd_d = own_data;
    end else if (txv_q && tx_ready_i) begin
      txv_d = 1'b0;
    end
  end

  // Arbitration FSM: pick owner, stream the packet, drain the line.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    last_g_d = last_g_q;
    cnt_d    = cnt_q;
    flush_d  = flush_q;
    cut_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rr_any) begin
          state_d          = S_XFER;
          gidx_d           = rr_pick;
          grant_d          = '0;
          grant_d[rr_pick] = 1'b1;
          cnt_d            = '0;
        end
      end
      S_XFER: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (own_last || cap_hit) begin
            state_d  = S_FLUSH;
            last_g_d = gidx_q;
            flush_d  = 2'd0;
            // A last byte that also hits the cap is a normal packet end.
            cut_d    = !own_last;
          end
        end
      end
      S_FLUSH: begin
        // Wait for the slot to empty, give uart_tx two cycles to raise
        // busy, then wait for the line to go idle.
        if (!txv_q) begin
          if (flush_q != 2'd2) begin
            flush_d = flush_q + 2'd1;
          end else if (!tx_busy_i) begin
            state_d = S_IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      last_g_q <= GW'(NREQ - 1);
      cnt_q    <= '0;
      flush_q  <= 2'd0;
      cut_q    <= 1'b0;
      txv_q    <= 1'b0;
      txd_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      last_g_q <= last_g_d;
      cnt_q    <= cnt_d;
      flush_q  <= flush_d;
      cut_q    <= cut_d;
      txv_q    <= txv_d;
      txd_q    <= txd_d;
    end
  end

  assign tx_valid_o  = txv_q;
  assign tx_data_o   = txd_q;
  assign grant_o     = grant_q;
  assign burst_cut_o = cut_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed bench for uart_tx_arb (NREQ=2, MAX_BURST=4).
// Requester queues feed the DUT. A small uart_tx model drives ready and
// busy. Every byte on the tx side is compared against a hand-ordered
// expected queue.
module tb_uart_tx_arb;
  localparam int NREQ      = 2;
  localparam int DW        = 8;
  localparam int MAX_BURST = 4;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_i;
  logic [NREQ-1:0]    req_valid_i;
  logic [NREQ*DW-1:0] req_data_i;
  logic [NREQ-1:0]    req_last_i;
  logic [NREQ-1:0]    req_ready_o;
  logic [DW-1:0]      tx_data_o;
  logic              tx_valid_o;
  logic              tx_ready_i;
  logic              tx_busy_i;
  logic [NREQ-1:0]    grant_o;
  logic              burst_cut_o;
  logic [1:0]         state_o;

  always #5 clk = ~clk;

  uart_tx_arb #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .tx_busy_i   (tx_busy_i),
    .grant_o     (grant_o),
    .burst_cut_o (burst_cut_o),
    .state_o     (state_o)
  );

  // ---------------- bench state ----------------
  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW:0]   rq0[$];
  logic [DW:0]   rq1[$];
  logic [NREQ-1:0] req_en = '1;
  int   ready_mode = 0;
  logic tgl = 1'b0;
  int   busy_cnt = 0;
  logic rst_v = 1'b1;
  int   acc0 = 0;
  int   acc1 = 0;
  int   cut_cnt = 0;
  int   cut_acc = 0;
  logic prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  logic [NREQ-1:0] s_grant, s_ready, s_valid;
  logic            s_txv, s_txr, s_cut;
  logic [DW-1:0]   s_txd;
  logic [1:0]      s_state;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step();
    @(negedge clk);
    rst_i          = rst_v;
    req_valid_i[0] = req_en[0] && (rq0.size() > 0);
    req_valid_i[1] = req_en[1] && (rq1.size() > 0);
    req_data_i     = '0;
    req_last_i     = '0;
    if (rq0.size() > 0) begin
      req_data_i[DW-1:0] = rq0[0][DW-1:0];
      req_last_i[0]      = rq0[0][DW];
    end
    if (rq1.size() > 0) begin
      req_data_i[2*DW-1:DW] = rq1[0][DW-1:0];
      req_last_i[1]         = rq1[0][DW];
    end
    tx_ready_i = (ready_mode == 1) ? tgl : (ready_mode == 0);
    tgl        = ~tgl;
    tx_busy_i  = (busy_cnt != 0);
    #4;
    s_grant = grant_o;
    s_ready = req_ready_o;
    s_valid = req_valid_i;
    s_txv   = tx_valid_o;
    s_txr   = tx_ready_i;
    s_txd   = tx_data_o;
    s_cut   = burst_cut_o;
    s_state = state_o;
    if (!rst_v) begin
      chk("ready_onehot0", 32'($onehot0(s_ready)), 1);
      if (s_state == 2'd2) chk("flush_ready", 32'(s_ready), 0);
      if (prev_hold) begin
        chk("hold_valid", 32'(s_txv), 1);
        chk("hold_data", 32'(s_txd), 32'(prev_data));
      end
    end
    prev_hold = s_txv && !s_txr && !rst_v;
    prev_data = s_txd;
    @(posedge clk);
    if (busy_cnt > 0) busy_cnt--;
    if (!rst_v) begin
      if (s_cut) begin
        cut_cnt++;
        cut_acc = acc0;
      end
      if (s_valid[0] && s_ready[0]) begin
        void'(rq0.pop_front());
        acc0++;
      end
      if (s_valid[1] && s_ready[1]) begin
        void'(rq1.pop_front());
        acc1++;
      end
      if (s_txv && s_txr) begin
        busy_cnt = 3;
        if (exp_q.size() == 0) chk("sb_qsize", 32'(exp_q.size()), 1);
        else chk("sb_data", 32'(s_txd), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic add0(input logic [DW-1:0] d, input logic l);
    rq0.push_back({l, d});
  endtask

  task automatic add1(input logic [DW-1:0] d, input logic l);
    rq1.push_back({l, d});
  endtask

  task automatic do_reset();
    rq0.delete();
    rq1.delete();
    exp_q.delete();
    busy_cnt  = 0;
    prev_hold = 1'b0;
    rst_v     = 1'b1;
    repeat (3) step();
    rst_v = 1'b0;
  endtask

  // Run until all queues drain and the grant is released; bounded.
  task automatic run_idle(input string tag, input int max);
    int   n;
    logic done;
    n    = 0;
    done = 1'b0;
    while (!done && n < max) begin
      step();
      n++;
      done = (s_grant == '0) && (rq0.size() == 0) && (rq1.size() == 0) && (exp_q.size() == 0);
    end
    chk(tag, 32'(done), 1);
  endtask

  task automatic wait_acc0(input string tag, input int target, input int max);
    int n;
    n = 0;
    while (acc0 < target && n < max) begin
      step();
      n++;
    end
    chk(tag, 32'(acc0 >= target), 1);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_grant"}, 32'(s_grant), 0);
    chk({pfx, "_ready"}, 32'(s_ready), 0);
    chk({pfx, "_txv"},   32'(s_txv), 0);
    chk({pfx, "_txd"},   32'(s_txd), 0);
    chk({pfx, "_cut"},   32'(s_cut), 0);
    chk({pfx, "_state"}, 32'(s_state), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_i       = 1'b1;
    req_valid_i = '0;
    req_data_i  = '0;
    req_last_i  = '0;
    tx_ready_i  = 1'b1;
    tx_busy_i   = 1'b0;

    // 1. Power-on reset.
    do_reset();
    step();
    chk_reset_outputs("por");

    // 2. Single packet 00,00,FF,00 from requester 0; arbitration and data latency.
    add0(8'h00, 1'b0); add0(8'h00, 1'b0); add0(8'hFF, 1'b0); add0(8'h00, 1'b1);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    step();
    chk("arb_idle_grant", 32'(s_grant), 0);
    step();
    chk("arb_grant", 32'(s_grant), 1);
    chk("arb_ready", 32'(s_ready), 1);
    step();
    chk("data_lat_valid", 32'(s_txv), 1);
    chk("data_lat_byte", 32'(s_txd), 32'h00);
    run_idle("single_done", 200);
    chk("single_idle_state", 32'(s_state), 0);

    // 3. Contention from reset: req0 wins first, then strict alternation.
    do_reset();
    add0(8'hA1, 1'b0); add0(8'hA2, 1'b1); add0(8'hA3, 1'b0); add0(8'hA4, 1'b1);
    add1(8'hB1, 1'b0); add1(8'hB2, 1'b1); add1(8'hB3, 1'b0); add1(8'hB4, 1'b1);
    foreach (exp_q[i]) exp_q[i] = exp_q[i];
    exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
    exp_q.push_back(8'hB1); exp_q.push_back(8'hB2);
    exp_q.push_back(8'hA3); exp_q.push_back(8'hA4);
    exp_q.push_back(8'hB3); exp_q.push_back(8'hB4);
    run_idle("contention_done", 400);

    // 4. Packet lock: req0 stalls after its first byte while req1 waits.
    add0(8'h01, 1'b0); add0(8'h02, 1'b0); add0(8'h03, 1'b1);
    add1(8'h11, 1'b0); add1(8'h12, 1'b1);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
    exp_q.push_back(8'h11); exp_q.push_back(8'h12);
    wait_acc0("lock_first_byte", acc0 + 1, 50);
    req_en[0] = 1'b0;
    repeat (10) begin
      step();
      chk("lock_grant", 32'(s_grant), 1);
      chk("lock_req1_ready", 32'(s_ready[1]), 0);
    end
    req_en[0] = 1'b1;
    run_idle("lock_done", 300);

    // 5. Burst cap: req0 cut after 4 bytes, req1 served, req0 resumes.
    cut_cnt = 0;
    add0(8'h21, 1'b0); add0(8'h22, 1'b0); add0(8'h23, 1'b0);
    add0(8'h24, 1'b0); add0(8'h25, 1'b0); add0(8'h26, 1'b1);
    add1(8'h31, 1'b0); add1(8'h32, 1'b1);
    exp_q.push_back(8'h21); exp_q.push_back(8'h22);
    exp_q.push_back(8'h23); exp_q.push_back(8'h24);
    exp_q.push_back(8'h31); exp_q.push_back(8'h32);
    exp_q.push_back(8'h25); exp_q.push_back(8'h26);
    cut_acc = 0;
    begin
      int base;
      base = acc0;
      run_idle("burst_done", 400);
      chk("burst_cut_count", 32'(cut_cnt), 1);
      chk("burst_cut_after4", 32'(cut_acc - base), 4);
    end

    // 6. Backpressure: tx_ready toggles; 4-byte packet ends on last, not on cap.
    ready_mode = 1;
    add0(8'h41, 1'b0); add0(8'h42, 1'b0); add0(8'h43, 1'b0); add0(8'h44, 1'b1);
    add1(8'h51, 1'b0); add1(8'h52, 1'b1);
    exp_q.push_back(8'h51); exp_q.push_back(8'h52);
    exp_q.push_back(8'h41); exp_q.push_back(8'h42);
    exp_q.push_back(8'h43); exp_q.push_back(8'h44);
    run_idle("bp_done", 400);
    chk("bp_no_cut", 32'(cut_cnt), 1);

    // 7. Reset mid-XFER with the output register stalled.
    ready_mode = 2;
    add0(8'h61, 1'b0); add0(8'h62, 1'b0); add0(8'h63, 1'b1);
    wait_acc0("midrst_accept", acc0 + 1, 50);
    step();
    chk("midrst_stalled", 32'(s_txv), 1);
    do_reset();
    step();
    chk_reset_outputs("midrst");

    chk("sb_left", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin, packet-locking arbiter that shares one `uart_tx` transmitter between `NREQ` byte-stream requesters, such as the console path and a protocol/boot responder. A grant is held until the requester's `last` byte or a `MAX_BURST` cap, so frames from different sources never interleave mid-packet. Between owners the block drains the line to idle. It sits between core-side byte sources and the `tx_data_i`/`tx_valid_i`/`tx_ready_o`/`busy_o` port of `uart_tx`.

## Interface
- `NREQ`, 2 — number of requesters (2..8).
- `DW`, 8 — byte width.
- `MAX_BURST`, 16 — max bytes per grant; 0 = unlimited (release only on `last`).

Clock and reset: one clock; reset is synchronous and active-high.
- `clk_i` in 1 — clock.
- `rst_i` in 1 — synchronous, active-high reset.
- `req_valid_i` in NREQ — per-requester byte valid.
- `req_data_i` in NREQ*DW — requester k occupies bits [k*DW +: DW].
- `req_last_i` in NREQ — byte is the final byte of a packet.
- `req_ready_o` out NREQ — byte accepted when valid&&ready; one-hot or zero.
- `tx_data_o` out DW — to `uart_tx.tx_data_i`.
- `tx_valid_o` out 1 — to `uart_tx.tx_valid_i`.
- `tx_ready_i` in 1 — from `uart_tx.tx_ready_o`.
- `tx_busy_i` in 1 — from `uart_tx.busy_o`.
- `grant_o` out NREQ — one-hot current owner; 0 when none.
- `burst_cut_o` out 1 — one-cycle pulse when a grant ends on `MAX_BURST` rather than `last`.

## Operation
- The output stage is a single register `{tx_valid_o, tx_data_o}`. It loads when it is empty or `tx_ready_i`=1. It empties on `tx_valid_o && tx_ready_i` with no reload.
- Owner g: `req_ready_o[g] = (state==XFER) && (!tx_valid_o || tx_ready_i)`. All other requesters see 0.
- **IDLE**
  - If any `req_valid_i` is set, pick the first set bit searching from `(last_g+1) mod NREQ` upward, wrapping.
  - Register `grant_o`, reset the burst counter to 0, and go to XFER.
- **XFER**
  - Each accepted byte increments the burst counter. The counter is `$clog2(MAX_BURST+1)` bits and saturates.
  - An accepted byte with `req_last_i[g]`=1 sets `last_g=g` and goes to FLUSH.
  - An accepted byte with count reaching `MAX_BURST` (when `MAX_BURST`≠0) without last does the same, and pulses `burst_cut_o` in the cycle after the handshake.
  - While waiting for the owner's valid, the grant is held indefinitely (packet lock).
- **FLUSH**
  - `req_ready_o`=0.
  - Stay until the output register is empty, then count 2 further cycles (covering `uart_tx`'s busy rise latency), then wait for `tx_busy_i`=0.
  - Then clear `grant_o` and go to IDLE.
- `grant_o` remains asserted throughout FLUSH.
- Arithmetic: requester index wrap uses modulo `NREQ`. `last_g` is `$clog2(NREQ)` bits.

## Timing
- Reset values: state=IDLE, `grant_o`=0, `req_ready_o`=0, `tx_valid_o`=0, `tx_data_o`=0, `burst_cut_o`=0, `last_g`=NREQ-1 (requester 0 wins first), burst counter=0.
- Reset mid-transfer discards the output register byte. No handshake completes in the reset cycle.
- Arbitration latency: a valid seen in IDLE at cycle t gives `grant_o` at t+1, and `req_ready_o` can be high at t+1.
- Data latency: a byte accepted at cycle t appears on `tx_valid_o`/`tx_data_o` at t+1. Throughput is one byte per cycle when `tx_ready_i` is held high.
- The output register holds data stable while `tx_valid_o && !tx_ready_i`.
- Simultaneous requests are resolved purely by round-robin order; no fixed priority.
- A requester dropping `req_valid_i` mid-packet does not release the grant.
- Minimum gap between owners: last handshake to next IDLE is at least 1 (drain) + 2 + the `tx_busy_i` low time.
- `req_valid_i` asserted during FLUSH by any requester is only sampled in IDLE.

## Test plan
- Reset: `rst_i` high for 3 cycles mid-XFER with `tx_ready_i`=0 → the cycle after release, all outputs at reset values and `grant_o`=0.
- Single packet: requester 0 sends 00,00,FF,00 (last on 4th), `tx_ready_i`=1 → `tx_data_o` shows 00,00,FF,00 on consecutive cycles starting 1 cycle after each accept, then FLUSH, then IDLE once `tx_busy_i`=0.
- Contention: req0 and req1 both valid from reset with 2-byte packets A1,A2 / B1,B2 → output A1,A2,B1,B2. Then both again → req0 serviced after req1 (round-robin from `last_g`=1 goes to 0), order A,B again; no interleave.
- Packet lock: req0 drops valid for 10 cycles after byte 1 while req1 is valid → `grant_o` stays 01 and no req1 byte is accepted until req0's last.
- Burst cap with `MAX_BURST`=4: req0 streams 6 bytes without last, req1 is waiting → after 4 bytes `burst_cut_o` pulses once, req1 is granted next, then req0 resumes.
- Backpressure: `tx_ready_i` toggles 0/1 each cycle → each byte is held stable while not ready, and no byte is lost or duplicated (scoreboard compare).
